// File: rtl/nice_gemm_cmd_if.sv
// NICE command interface for the GEMM engine: parameter-pair slots, status, launch and response.
// Define NICE_CYCLE_CNT_EN to report the RUN cycle count in the multi-cycle response data.
module nice_gemm_cmd_if #(
  parameter int unsigned NPAIR = 6,
  parameter int unsigned DW    = 32,
  parameter logic [6:0]  OPC   = 7'b0101011
) (
  input  logic                  nice_clk,
  input  logic                  nice_rst_n,
  input  logic                  nice_req_valid,
  output logic                  nice_req_ready,
  input  logic [31:0]           nice_req_instr,
  input  logic [31:0]           nice_req_rs1,
  input  logic [31:0]           nice_req_rs2,
  output logic                  nice_rsp_1cyc_type,
  output logic [31:0]           nice_rsp_1cyc_dat,
  output logic                  nice_rsp_1cyc_err,
  output logic                  nice_rsp_multicyc_valid,
  input  logic                  nice_rsp_multicyc_ready,
  output logic [31:0]           nice_rsp_multicyc_dat,
  output logic                  nice_rsp_multicyc_err,
  output logic [2*NPAIR*DW-1:0] param_flat,
  output logic [NPAIR-1:0]      param_vld,
  output logic                  start,
  input  logic                  engine_done,
  input  logic                  engine_err
);

  typedef enum logic [1:0] {IDLE, RUN, RESP} state_t;

  state_t           state_q, state_d;
  logic [6:0]       funct7;
  logic             opc_hit, is_set, is_status, is_start, is_illegal;
  logic             accept;
  logic [NPAIR-1:0] set_mask, vld_new;
  logic             start_d, mc_load, mc_err_d;
  logic [31:0]      mc_dat_d;
  logic             unused_instr;

  assign funct7       = nice_req_instr[31:25];
  assign opc_hit      = (nice_req_instr[6:0] == OPC);
  assign unused_instr = ^nice_req_instr[24:7];

  // One-hot funct7 selects a parameter slot; bits at or above NPAIR never match
  always_comb begin
    set_mask = '0;
    for (int k = 0; k < NPAIR; k++) begin
      if (funct7 == 7'(1 << k)) set_mask[k] = 1'b1;
    end
  end

  assign is_set     = opc_hit & (|set_mask);
  assign is_status  = opc_hit & (funct7 == 7'd0);
  assign is_start   = opc_hit & (funct7 == 7'b1000000);
  assign is_illegal = ~(is_set | is_status | is_start);
  assign vld_new    = param_vld | (is_set ? set_mask : '0);

`ifdef NICE_CYCLE_CNT_EN
  logic [31:0] cnt_q, cnt_inc;

  assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + 32'd1;

  // Saturating count of RUN cycles since the last accepted START
  always_ff @(posedge nice_clk) begin
    if (!nice_rst_n)             cnt_q <= '0;
    else if (accept && is_start) cnt_q <= '0;
    else if (state_q == RUN)     cnt_q <= cnt_inc;
  end
`endif

  always_ff @(posedge nice_clk) begin
    if (!nice_rst_n) state_q <= IDLE;
    else             state_q <= state_d;
  end

  always_comb begin
    state_d                 = state_q;
    nice_req_ready          = 1'b0;
    accept                  = 1'b0;
    nice_rsp_1cyc_type      = 1'b0;
    nice_rsp_1cyc_err       = 1'b0;
    nice_rsp_1cyc_dat       = '0;
    nice_rsp_multicyc_valid = 1'b0;
    start_d                 = 1'b0;
    mc_load                 = 1'b0;
    mc_err_d                = 1'b0;
    mc_dat_d                = '0;
    case (state_q)
      IDLE: begin
        nice_req_ready = 1'b1;
        accept         = nice_req_valid;
        if (accept) begin
          if (is_start) begin
            if (&param_vld) begin
              start_d = 1'b1;
              state_d = RUN;
            end else begin
              mc_load  = 1'b1;
              mc_err_d = 1'b1;
              state_d  = RESP;
            end
          end else begin
            nice_rsp_1cyc_type = 1'b1;
            nice_rsp_1cyc_err  = is_illegal;
            nice_rsp_1cyc_dat  = is_illegal ? 32'd0 : 32'(vld_new);
          end
        end
      end
      RUN: begin
        if (engine_done) begin
          mc_load  = 1'b1;
          mc_err_d = engine_err;
`ifdef NICE_CYCLE_CNT_EN
          mc_dat_d = cnt_inc;
`endif
          state_d  = RESP;
        end
      end
      RESP: begin
        nice_rsp_multicyc_valid = 1'b1;
        if (nice_rsp_multicyc_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Parameter slots, launch pulse and held multi-cycle response
  always_ff @(posedge nice_clk) begin
    if (!nice_rst_n) begin
      param_flat            <= '0;
      param_vld             <= '0;
      start                 <= 1'b0;
      nice_rsp_multicyc_dat <= '0;
      nice_rsp_multicyc_err <= 1'b0;
    end else begin
      start <= start_d;
      if (mc_load) begin
        nice_rsp_multicyc_dat <= mc_dat_d;
        nice_rsp_multicyc_err <= mc_err_d;
      end
      if (accept && is_set) begin
        for (int k = 0; k < NPAIR; k++) begin
          if (set_mask[k]) begin
            param_flat[(2*k)*DW +: DW]   <= DW'(nice_req_rs1);
            param_flat[(2*k+1)*DW +: DW] <= DW'(nice_req_rs2);
            param_vld[k]                 <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: doc/nice_gemm_cmd_if.md
NICE_GEMM_CMD_IF -- requirements
Module: nice_gemm_cmd_if

Interface
REQ-001 SHALL provide parameter NPAIR, default 6, range 1..6: number of writable rs1/rs2 parameter-pair slots.
REQ-002 SHALL provide parameter DW, default 32: width of each parameter register.
REQ-003 SHALL provide parameter OPC, default 7'b0101011: custom opcode accepted in instr[6:0].
REQ-004 nice_clk  in  1  sole clock; all state changes on its rising edge.
REQ-005 nice_rst_n  in  1  reset, synchronous, active-low.
REQ-006 nice_req_valid / nice_req_ready  in / out  1 / 1  request handshake.
REQ-007 nice_req_instr, nice_req_rs1, nice_req_rs2  in  32 each  instruction word and operands.
REQ-008 nice_rsp_1cyc_type, nice_rsp_1cyc_err  out  1  single-cycle response flags; nice_rsp_1cyc_dat  out  32.
REQ-009 nice_rsp_multicyc_valid / nice_rsp_multicyc_ready  out / in  1; nice_rsp_multicyc_dat  out  32; nice_rsp_multicyc_err  out  1.
REQ-010 param_flat  out  2*NPAIR*DW  slot k rs1 at bits [(2k)*DW +: DW], rs2 at [(2k+1)*DW +: DW].
REQ-011 param_vld  out  NPAIR  per-slot written-since-reset flag.
REQ-012 start  out  1  one-cycle engine launch pulse; engine_done, engine_err  in  1 each  engine completion and fault.

Function
REQ-013 Accept = nice_req_valid & nice_req_ready; nice_req_ready SHALL be 1 only in state IDLE.
REQ-014 Decode on accept: SET_k = opcode==OPC and funct7==(1<<k), k<NPAIR; STATUS = opcode==OPC and funct7==0; START = opcode==OPC and funct7==7'b1000000; all else ILLEGAL.
REQ-015 SET_k SHALL load slot k with rs1/rs2 and set param_vld[k] on the accept edge; other slots unchanged.
REQ-016 SET, STATUS and ILLEGAL are single-cycle: nice_rsp_1cyc_type=1 combinationally in the accept cycle; state stays IDLE.
REQ-017 nice_rsp_1cyc_dat SHALL be zero-extended {param_vld | (SET_k ? 1<<k : 0)} for SET/STATUS, 0 for ILLEGAL.
REQ-018 nice_rsp_1cyc_err SHALL be 1 only for accepted ILLEGAL (incl. funct7 one-hot bit k>=NPAIR); it is 0 when no accept occurs.
REQ-019 START with param_vld all-ones: next cycle start=1 for exactly one cycle, state IDLE->RUN.
REQ-020 START with any param_vld bit 0: no start pulse; state IDLE->RESP with multicyc_err=1, multicyc_dat=0.
REQ-021 RUN: nice_req_ready=0; on engine_done=1 SHALL go to RESP, latching multicyc_err=engine_err; engine_done outside RUN is ignored.
REQ-022 RESP: nice_rsp_multicyc_valid=1 with dat/err held stable until multicyc_ready=1; on that edge -> IDLE.
REQ-023 multicyc_ready=1 in the cycle valid first rises SHALL complete the handshake in that same cycle.
REQ-024 Parameters and param_vld SHALL persist across START; they are cleared only by reset.
REQ-025 nice_rsp_multicyc_valid SHALL be 0 in IDLE and RUN.

Reset
REQ-026 On nice_clk edge with nice_rst_n=0: state=IDLE, param_flat=0, param_vld=0, start=0, multicyc_valid=0, multicyc_dat=0, multicyc_err=0, cycle counter=0.
REQ-027 Reset in RUN or RESP SHALL abort the operation, drop a pending response without handshake, and not pulse start.
REQ-028 Combinational outputs (nice_req_ready=1, 1cyc flags=0) SHALL follow reset state in the next cycle.

Configuration
REQ-029 With NICE_CYCLE_CNT_EN defined: a 32-bit counter cleared on START accept, incremented each RUN cycle, saturating at 0xFFFFFFFF; multicyc_dat on engine completion = counter value.
REQ-030 Without NICE_CYCLE_CNT_EN: no counter logic; multicyc_dat=0 for every response.

Verification
REQ-031 Reset, SET_0..SET_5 with rs1=0x10+k, rs2=0x20+k -> 1cyc_type=1, dat=0x1,0x3,...,0x3F; param_flat slots match; err=0.
REQ-032 Reset, SET_0 only, START -> no start pulse; multicyc_valid=1, err=1, dat=0; ready=1 -> IDLE next cycle.
REQ-033 All slots set, START, engine_done after 10 RUN cycles, err=0, NICE_CYCLE_CNT_EN defined -> one start pulse, multicyc_dat=10, err=0; without macro dat=0.
REQ-034 RESP with multicyc_ready=0 for 5 cycles -> valid, dat, err stable, nice_req_ready=0; ready=1 -> IDLE.
REQ-035 Opcode 0x0B, and funct7=7'b0100000 with NPAIR=4 -> 1cyc_err=1, dat=0, no register change.
REQ-036 nice_rst_n=0 for one cycle during RUN -> IDLE, param_vld=0, no response; subsequent START -> err response.
